adder_sequencer: RTL
====================

Name: adder_sequencer

Overview:
- Multi-cycle controller that performs NBYTES-wide add/subtract by time-sharing one external 8-bit ripple-carry adder instance.
- Feeds the adder one operand byte per cycle, LSB byte first, and chains the carry through an internal register.
- Sits between the ALU control logic and the shared ripplecarry_adder_8bit.
- Provides a start/busy/done handshake.

Parameters:
NBYTES, 2, operand width in bytes; legal range 1..8.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new operation; sampled only in IDLE.
sub  input  1  0 = A+B, 1 = A-B; latched on an accepted start.
op_a  input  8*NBYTES  operand A; latched on an accepted start.
op_b  input  8*NBYTES  operand B; latched on an accepted start.
busy  output  1  high while an operation is in progress (CALC or DONE).
done  output  1  single-cycle pulse; result, carry and overflow are valid.
result  output  8*NBYTES  sum or difference; held until the next accepted start.
carry_out  output  1  final adder carry; for subtract, 1 = no borrow.
overflow  output  1  two's-complement signed overflow of the full-width result.
adder_a  output  8  byte of A driven to the external adder.
adder_b  output  8  byte of B (inverted when sub=1) driven to the external adder.
adder_cin  output  1  carry-in to the external adder.
adder_sum  input  8  sum returned from the external adder (combinational).
adder_cout  input  1  carry-out returned from the external adder (combinational).

Behaviour:
- Reset: asynchronous, active-low.
  - Outputs cleared: busy=0, done=0, result=0, carry_out=0, overflow=0, adder_a=0, adder_b=0, adder_cin=0.
  - Internal state cleared: state=IDLE, byte index=0, carry register=0.
  - An assertion mid-operation aborts the operation immediately; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches op_a, op_b and sub.
  - Carry register <= sub; byte index <= 0; next state CALC.
  - start=0: stay in IDLE.
- CALC (one cycle per byte, index i = 0..NBYTES-1):
  - Combinational drive: adder_a = A[8i+7:8i]; adder_b = B[8i+7:8i] XOR {8{sub}}; adder_cin = carry register.
  - On the clock edge: result[8i+7:8i] <= adder_sum; carry register <= adder_cout.
  - At i = NBYTES-1:
    - carry_out <= adder_cout.
    - overflow <= (adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]).
    - Next state DONE.
  - Otherwise i <= i+1.
- DONE: done=1 for exactly one cycle, then return to IDLE. A start during DONE is ignored.
- adder_a, adder_b and adder_cin are 0 in IDLE and DONE.
- busy=1 in CALC and DONE.
- Latency:
  - start sampled at edge 0.
  - CALC occupies cycles 1..NBYTES.
  - done is high in cycle NBYTES+1.
  - Next start is accepted in cycle NBYTES+2 at the earliest.
- start while busy is ignored; the operation in progress and its latched operands are unaffected.
- Operand inputs may change freely after the accepting edge.
- result updates byte-wise during CALC; it is defined as valid only while done=1 and afterwards until the next accepted start.
- carry_out and overflow hold their value until the last CALC cycle of the next operation.
- NBYTES=1: a single CALC cycle; done is high in cycle 2.

Test Plan:
- NBYTES=2, sub=0, A=0x00FF, B=0x0001, pulse start -> done high exactly 3 cycles after the start edge; result=0x0100, carry_out=0, overflow=0. Carry propagates from byte 0 to byte 1 (adder_cin=1 in the second CALC cycle).
- sub=0, A=0xFFFF, B=0x0001 -> result=0x0000, carry_out=1, overflow=0. Then A=0x7FFF, B=0x0001 -> result=0x8000, carry_out=0, overflow=1.
- sub=1, A=0x0100, B=0x0001 -> result=0x00FF, carry_out=1, overflow=0. Then sub=1, A=0x0000, B=0x0001 -> result=0xFFFF, carry_out=0 (borrow), overflow=0. Then sub=1, A=0x8000, B=0x0001 -> result=0x7FFF, overflow=1.
- start held high continuously with operands changed every cycle -> each operation uses the operands latched at its accepting edge. Accepting edges are exactly NBYTES+2 cycles apart. Exactly one done pulse per operation.
- Assert rst_n=0 during the first CALC cycle of A=0x1234 + B=0x1111 -> all outputs 0 immediately, no done pulse. After release, a new operation A=0x0001 + B=0x0002 returns 0x0003 with normal latency.
- Bench with NBYTES=1: A=0x80, B=0x80, sub=0 -> result=0x00, carry_out=1, overflow=1, done high in cycle 2.

Source files
------------

// File: rtl/adder_sequencer.sv
// adder_sequencer: NBYTES-wide add/subtract built by time-sharing one external
// 8-bit ripple-carry adder. After a start is accepted, one operand byte per
// cycle goes to the adder, least significant byte first. The carry between
// bytes is kept in an internal register. Subtraction is A + ~B + 1.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   start, sub            operation request (seen only in IDLE); 0=A+B, 1=A-B
//   op_a, op_b            operands, latched when start is accepted
//   busy, done            busy in CALC/DONE; done is a one-cycle result-valid pulse
//   result                sum/difference, held until the next accepted start
//   carry_out, overflow   final adder carry (1 = no borrow when subtracting);
//                         signed overflow
//   adder_a/b/cin         byte operands and carry-in to the external adder
//   adder_sum/cout        combinational result from the external adder
module adder_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [7:0]            adder_a,
  output logic [7:0]            adder_b,
  output logic                  adder_cin,
  input  logic [7:0]            adder_sum,
  input  logic                  adder_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q;
  logic          carry_q;
  logic          last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The adder operand outputs are decoded from state. This makes them zero
  // in IDLE and DONE, and zero at once when reset is asserted.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy      = 1'b1;
        adder_a   = a_q[8*idx +: 8];
        adder_b   = b_q[8*idx +: 8] ^ {8{sub_q}};
        adder_cin = carry_q;
        last      = (idx == LAST);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= sub;
            carry_q <= sub;   // carry-in of 1 completes the two's complement of B
            idx     <= '0;
          end
        end
        CALC: begin
          result[8*idx +: 8] <= adder_sum;
          carry_q            <= adder_cout;
          if (last) begin
            carry_out <= adder_cout;
            overflow  <= (adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
